// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: request/grant handshake plus bus transaction strobes.
// The arbiter connects through the slave modport. The requesters and bus side
// connect through the master modport.
interface bus_arbiter_if #(
  parameter int NR_MASTERS = 4
);
  localparam int IDX_W = $clog2(NR_MASTERS);

  logic [NR_MASTERS-1:0] request;
  logic [NR_MASTERS-1:0] grants;
  logic                  begin_transactionIN;
  logic                  end_transactionIN;
  logic                  data_validIN;
  logic                  end_transactionOUT;
  logic                  errorOUT;
  logic [IDX_W-1:0]      current_master;
  logic                  bus_idle;

  modport master (
    output request, begin_transactionIN, end_transactionIN, data_validIN,
    input  grants, end_transactionOUT, errorOUT, current_master, bus_idle
  );

  modport slave (
    input  request, begin_transactionIN, end_transactionIN, data_validIN,
    output grants, end_transactionOUT, errorOUT, current_master, bus_idle
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a single-cycle grant pulse and no preemption.
// Optional feature macro BUS_ARBITER_TIMEOUT_EN: a 16-bit watchdog in
// WAIT_BEGIN/OWNED forces a release with end_transactionOUT/errorOUT pulses
// after TIMEOUT_CYCLES cycles without bus activity. Without the macro, no
// counter is built and both pulse outputs stay 0.
module bus_arbiter #(
  parameter int NR_MASTERS     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                system_clock,
  input logic                system_reset_n,
  bus_arbiter_if.slave       bus
);
  localparam int IDX_W = $clog2(NR_MASTERS);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_GRANT      = 2'd1,
    S_WAIT_BEGIN = 2'd2,
    S_OWNED      = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [NR_MASTERS-1:0] r_grants;
  logic [NR_MASTERS-1:0] w_grants_next;
  logic [NR_MASTERS-1:0] w_grant_onehot;
  logic [IDX_W-1:0]      r_current_master;
  logic [IDX_W-1:0]      w_current_master_next;
  logic [IDX_W-1:0]      r_last_owner;
  logic [IDX_W-1:0]      w_last_owner_next;
  logic [IDX_W-1:0]      w_winner;
  logic                  w_found;
  logic                  r_end_out;
  logic                  r_error;
  logic                  w_end_out_next;
  logic                  w_error_next;
  logic                  w_timeout;

  // Round-robin search: the candidate closest after last_owner (with wrap) wins.
  // Scanning from the farthest candidate to the nearest lets the nearest overwrite.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = NR_MASTERS; i >= 1; i--) begin
      w_winner = bus.request[(int'(r_last_owner) + i) % NR_MASTERS]
               ? IDX_W'((int'(r_last_owner) + i) % NR_MASTERS) : w_winner;
      w_found  = w_found | bus.request[(int'(r_last_owner) + i) % NR_MASTERS];
    end
  end

  // One-hot grant vector for the selected winner.
  always_comb begin
    w_grant_onehot           = '0;
    w_grant_onehot[w_winner] = 1'b1;
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_watchdog;
  logic [15:0] w_watchdog_inc;
  logic        w_bus_active;
  logic        w_watch_state;
  logic        w_watchdog_run;

  assign w_watchdog_inc = r_watchdog + 16'd1;
  assign w_bus_active   = bus.begin_transactionIN | bus.data_validIN;
  assign w_watch_state  = (r_state == S_WAIT_BEGIN) || (r_state == S_OWNED);
  assign w_timeout      = w_watch_state && !w_bus_active && (w_watchdog_inc == TIMEOUT_VAL);
  // The counter only keeps running while the arbiter stays in the same watched state.
  assign w_watchdog_run = w_watch_state && (w_state_next == r_state) && !w_bus_active;

  // Watchdog counter: cleared on state entry or bus activity, otherwise counts up.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_watchdog <= 16'd0;
    end else begin
      r_watchdog <= w_watchdog_run ? w_watchdog_inc : 16'd0;
    end
  end
`else
  logic w_unused_data_valid;

  assign w_unused_data_valid = bus.data_validIN;
  assign w_timeout           = 1'b0;
`endif

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    w_state_next          = r_state;
    w_grants_next         = '0;
    w_current_master_next = r_current_master;
    w_last_owner_next     = r_last_owner;
    w_end_out_next        = 1'b0;
    w_error_next          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_next          = S_GRANT;
          w_current_master_next = w_winner;
          w_grants_next         = w_grant_onehot;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_GRANT: begin
        w_state_next = S_WAIT_BEGIN;
      end
      S_WAIT_BEGIN: begin
        if (bus.begin_transactionIN && bus.end_transactionIN) begin
          w_state_next      = S_IDLE;
          w_last_owner_next = r_current_master;
        end else if (bus.begin_transactionIN) begin
          w_state_next = S_OWNED;
        end else if (!bus.request[r_current_master]) begin
          w_state_next      = S_IDLE;
          w_last_owner_next = r_current_master;
        end else if (w_timeout) begin
          w_state_next      = S_IDLE;
          w_last_owner_next = r_current_master;
          w_end_out_next    = 1'b1;
          w_error_next      = 1'b1;
        end else begin
          w_state_next = S_WAIT_BEGIN;
        end
      end
      S_OWNED: begin
        // A real end in the timeout cycle is a normal release and raises no error.
        if (bus.end_transactionIN) begin
          w_state_next      = S_IDLE;
          w_last_owner_next = r_current_master;
        end else if (w_timeout) begin
          w_state_next      = S_IDLE;
          w_last_owner_next = r_current_master;
          w_end_out_next    = 1'b1;
          w_error_next      = 1'b1;
        end else begin
          w_state_next = S_OWNED;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_state          <= S_IDLE;
      r_grants         <= '0;
      r_current_master <= '0;
      r_last_owner     <= IDX_W'(NR_MASTERS - 1);
      r_end_out        <= 1'b0;
      r_error          <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_grants         <= w_grants_next;
      r_current_master <= w_current_master_next;
      r_last_owner     <= w_last_owner_next;
      r_end_out        <= w_end_out_next;
      r_error          <= w_error_next;
    end
  end

  // Registered idle flag. It follows the next state, so it is high exactly in IDLE.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      bus.bus_idle <= 1'b1;
    end else begin
      bus.bus_idle <= (w_state_next == S_IDLE);
    end
  end

  assign bus.grants             = r_grants;
  assign bus.current_master     = r_current_master;
  assign bus.end_transactionOUT = r_end_out;
  assign bus.errorOUT           = r_error;
endmodule
